// File: rtl/lv_frame_sequencer_pkg.sv
// Shared types and constants for the LinearVisualizer frame sequencer.
// The LV latency default is also used by the LV itself, so both stay in step.
package lv_frame_sequencer_pkg;

  localparam int LV_LATENCY_DEFAULT = 9;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SNAP,
    STREAM,
    PAD,
    DONE
  } seq_state_t;

endpackage

// File: rtl/lv_run_expander.sv
// Snapshots the LV colour/count arrays and expands them run-length style into
// exactly LEDS colour words on a valid/ready stream. Bin 0 sits in the LSBs.
module lv_run_expander #(
  parameter int LEDS    = 50,
  parameter int BIN_QTY = 12,
  parameter int CW      = $clog2(LEDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_snap,
  input  logic                  i_stream,
  input  logic                  i_pad,
  input  logic [BIN_QTY*24-1:0] i_rgb,
  input  logic [BIN_QTY*CW-1:0] i_counts,
  input  logic                  i_led_ready,
  output logic [23:0]           o_led_word,
  output logic                  o_led_v,
  output logic                  o_led_last,
  output logic                  o_to_pad,
  output logic                  o_to_done
);

  localparam int IW = $clog2(LEDS + 1);
  localparam int BW = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;

  logic [23:0]   r_rgb    [BIN_QTY];
  logic [CW-1:0] r_counts [BIN_QTY];
  logic [BW-1:0] r_bin;
  logic [CW-1:0] r_remaining;
  logic [IW-1:0] r_led_idx;

  logic [BW-1:0] w_next_bin;
  logic          w_run_live;
  logic          w_hs;
  logic          w_last_bin;
  logic          w_run_ends;
  logic          w_advance;

  // A bin with remaining==0 while streaming is a zero-count bubble: no valid word.
  assign w_run_live = (r_remaining != '0);
  assign o_led_v    = i_pad || (i_stream && w_run_live);
  assign o_led_word = (i_stream && w_run_live) ? r_rgb[r_bin] : 24'h000000;
  assign o_led_last = o_led_v && (r_led_idx == IW'(LEDS - 1));
  assign w_hs       = o_led_v && i_led_ready;

  assign w_next_bin = r_bin + BW'(1);
  assign w_last_bin = (r_bin == BW'(BIN_QTY - 1));
  assign w_run_ends = i_stream && (!w_run_live || (w_hs && r_remaining == CW'(1)));
  assign o_to_done  = w_hs && (r_led_idx == IW'(LEDS - 1));
  assign o_to_pad   = w_run_ends && w_last_bin && !o_to_done;
  assign w_advance  = w_run_ends && !w_last_bin && !o_to_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < BIN_QTY; b++) begin
        r_rgb[b]    <= '0;
        r_counts[b] <= '0;
      end
      r_bin       <= '0;
      r_remaining <= '0;
      r_led_idx   <= '0;
    end else if (i_snap) begin
      for (int b = 0; b < BIN_QTY; b++) begin
        r_rgb[b]    <= i_rgb[b*24 +: 24];
        r_counts[b] <= i_counts[b*CW +: CW];
      end
      r_bin       <= '0;
      r_remaining <= i_counts[CW-1:0];
      r_led_idx   <= '0;
    end else begin
      if (w_hs && r_led_idx != IW'(LEDS))
        r_led_idx <= r_led_idx + IW'(1);
      if (w_advance) begin
        r_bin       <= w_next_bin;
        r_remaining <= r_counts[w_next_bin];
      end else if (w_hs && i_stream) begin
        r_remaining <= r_remaining - CW'(1);
      end
    end
  end

endmodule

// File: rtl/lv_frame_sequencer.sv
// Runs the LV one note frame at a time: accept, strobe lv_start, wait out the
// LV latency, then hand a snapshot of its outputs to the run expander.
module lv_frame_sequencer
  import lv_frame_sequencer_pkg::*;
#(
  parameter int LEDS       = 50,
  parameter int BIN_QTY    = 12,
  parameter int LV_LATENCY = LV_LATENCY_DEFAULT,
  parameter int CW         = $clog2(LEDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  notes_v,
  output logic                  notes_ready,
  output logic                  lv_start,
  input  logic                  lv_data_v,
  input  logic [BIN_QTY*24-1:0] lv_rgb,
  input  logic [BIN_QTY*CW-1:0] lv_counts,
  output logic [23:0]           led_word,
  output logic                  led_v,
  input  logic                  led_ready,
  output logic                  led_last,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int WW = (LV_LATENCY > 2) ? $clog2(LV_LATENCY) : 1;

  seq_state_t    r_state;
  seq_state_t    w_next;
  logic [WW-1:0] r_wait;
  logic          w_accept;
  logic          w_to_pad;
  logic          w_to_done;

  // Acceptance and lv_start are combinational so the LV samples the notes on the accepting edge.
  assign notes_ready = (r_state == IDLE) && !rst;
  assign w_accept    = notes_v && notes_ready;
  assign lv_start    = w_accept;
  assign busy        = (r_state != IDLE);
  assign frame_done  = (r_state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_wait <= '0;
    else if (w_accept)
      r_wait <= WW'(LV_LATENCY - 1);
    else if (r_state == WAIT && r_wait != '0)
      r_wait <= r_wait - WW'(1);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = WAIT;
      WAIT:    if (r_wait == '0 && lv_data_v) w_next = SNAP;
      SNAP:    w_next = STREAM;
      STREAM:  if (w_to_done) w_next = DONE;
               else if (w_to_pad) w_next = PAD;
      PAD:     if (w_to_done) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  lv_run_expander #(
    .LEDS    (LEDS),
    .BIN_QTY (BIN_QTY),
    .CW      (CW)
  ) u_expander (
    .clk         (clk),
    .rst         (rst),
    .i_snap      (r_state == SNAP),
    .i_stream    (r_state == STREAM),
    .i_pad       (r_state == PAD),
    .i_rgb       (lv_rgb),
    .i_counts    (lv_counts),
    .i_led_ready (led_ready),
    .o_led_word  (led_word),
    .o_led_v     (led_v),
    .o_led_last  (led_last),
    .o_to_pad    (w_to_pad),
    .o_to_done   (w_to_done)
  );

endmodule

// File: tb/tb_lv_frame_sequencer.sv
// Directed and randomized frames for lv_frame_sequencer, checked against a
// list-based expansion of the bin counts computed inside the bench.
module tb_lv_frame_sequencer;

  localparam int LEDS    = 50;
  localparam int BIN_QTY = 12;
  localparam int LV_LAT  = 9;
  localparam int CW      = $clog2(LEDS);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  notes_v;
  logic                  notes_ready;
  logic                  lv_start;
  logic                  lv_data_v;
  logic [BIN_QTY*24-1:0] lv_rgb;
  logic [BIN_QTY*CW-1:0] lv_counts;
  logic [23:0]           led_word;
  logic                  led_v;
  logic                  led_ready;
  logic                  led_last;
  logic                  frame_done;
  logic                  busy;

  int          total = 0;
  int          bad   = 0;
  int          cnt [BIN_QTY];
  logic [23:0] rgb [BIN_QTY];

  lv_frame_sequencer #(
    .LEDS       (LEDS),
    .BIN_QTY    (BIN_QTY),
    .LV_LATENCY (LV_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .notes_v     (notes_v),
    .notes_ready (notes_ready),
    .lv_start    (lv_start),
    .lv_data_v   (lv_data_v),
    .lv_rgb      (lv_rgb),
    .lv_counts   (lv_counts),
    .led_word    (led_word),
    .led_v       (led_v),
    .led_ready   (led_ready),
    .led_last    (led_last),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randomRgb();
    for (int b = 0; b < BIN_QTY; b++) rgb[b] = 24'($urandom);
  endtask

  task automatic driveLv();
    for (int b = 0; b < BIN_QTY; b++) begin
      lv_rgb[b*24 +: 24]    = rgb[b];
      lv_counts[b*CW +: CW] = CW'(cnt[b]);
    end
  endtask

  // Runs one frame; pct is the led_ready duty, dly the first cycle lv_data_v is high,
  // rstAt the word index at which reset is injected (-1 for none).
  task automatic applyStimulus(input int pct, input int dly, input int rstAt, input string tag);
    logic [23:0] expW[$];
    int          bubbles = 0;
    int          widx = 0;
    int          firstStream;
    bit          seenV = 0, stalled = 0, done = 0, rdy;
    logic [23:0] prevWord = '0;
    logic        prevLast = 1'b0;

    for (int b = 0; b < BIN_QTY && expW.size() < LEDS; b++) begin
      if (cnt[b] == 0) bubbles++;
      for (int k = 0; k < cnt[b] && expW.size() < LEDS; k++) expW.push_back(rgb[b]);
    end
    while (expW.size() < LEDS) expW.push_back(24'h000000);
    firstStream = ((dly > LV_LAT) ? dly : LV_LAT) + 2;

    driveLv();
    lv_data_v = (dly <= 0);
    notes_v   = 1'b1;
    #1;
    checkOutput({tag, "_notes_ready"}, notes_ready, 1);
    checkOutput({tag, "_lv_start"}, lv_start, 1);
    @(posedge clk); #1;

    for (int c = 1; c < 1000 && !done; c++) begin
      lv_data_v = (c >= dly);
      if (!frame_done) begin
        checkOutput({tag, "_stall_ready"}, notes_ready, 0);
        checkOutput({tag, "_stall_start"}, lv_start, 0);
      end
      if (led_v && !seenV) begin
        seenV = 1;
        if (cnt[0] != 0) checkOutput({tag, "_first_v_cycle"}, c, firstStream);
        for (int b = 0; b < BIN_QTY; b++) begin
          lv_rgb[b*24 +: 24]    = 24'($urandom);
          lv_counts[b*CW +: CW] = CW'($urandom);
        end
      end
      if (stalled) begin
        checkOutput({tag, "_hold_v"}, led_v, 1);
        checkOutput({tag, "_hold_word"}, led_word, prevWord);
        checkOutput({tag, "_hold_last"}, led_last, prevLast);
      end
      if (led_v) begin
        checkOutput({tag, "_word"}, led_word, (widx < LEDS) ? expW[widx] : 24'hxxxxxx);
        checkOutput({tag, "_last"}, led_last, (widx == LEDS - 1));
      end
      if (frame_done) begin
        checkOutput({tag, "_word_count"}, widx, LEDS);
        if (pct >= 100) checkOutput({tag, "_done_cycle"}, c, firstStream + LEDS + bubbles);
        notes_v = 1'b0;
        done    = 1;
        @(posedge clk); #1;
        checkOutput({tag, "_done_pulse"}, frame_done, 0);
        checkOutput({tag, "_idle_busy"}, busy, 0);
      end else if (rstAt >= 0 && led_v && widx == rstAt) begin
        rst = 1'b1;
        #1;
        checkOutput({tag, "_rst_led_v"}, led_v, 0);
        checkOutput({tag, "_rst_busy"}, busy, 0);
        checkOutput({tag, "_rst_word"}, led_word, 0);
        checkOutput({tag, "_rst_ready"}, notes_ready, 0);
        notes_v = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        done = 1;
      end else begin
        rdy       = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
        led_ready = rdy;
        stalled   = led_v && !rdy;
        prevWord  = led_word;
        prevLast  = led_last;
        if (led_v && rdy) widx++;
        @(posedge clk); #1;
      end
    end
    checkOutput({tag, "_finished"}, done, 1);
  endtask

  initial begin
    rst       = 1'b1;
    notes_v   = 1'b0;
    lv_data_v = 1'b0;
    led_ready = 1'b0;
    lv_rgb    = '0;
    lv_counts = '0;
    #1;
    checkOutput("reset_notes_ready", notes_ready, 0);
    checkOutput("reset_lv_start", lv_start, 0);
    checkOutput("reset_led_v", led_v, 0);
    checkOutput("reset_led_last", led_last, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_led_word", led_word, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("idle_notes_ready", notes_ready, 1);
    checkOutput("idle_busy", busy, 0);

    $display("[TB] frame sum 50");
    cnt = '{5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5};
    randomRgb();
    applyStimulus(100, 0, -1, "sum50");

    $display("[TB] frame sum 40 with empty bin 3");
    cnt = '{4, 4, 4, 0, 4, 4, 4, 4, 4, 4, 2, 2};
    randomRgb();
    applyStimulus(100, 0, -1, "sum40");

    $display("[TB] frame sum 60");
    cnt = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
    randomRgb();
    applyStimulus(100, 0, -1, "sum60");

    $display("[TB] random frames with random led_ready");
    for (int f = 0; f < 4; f++) begin
      for (int b = 0; b < BIN_QTY; b++) cnt[b] = $urandom_range(0, 8);
      randomRgb();
      applyStimulus(50, 0, -1, "rand");
    end

    $display("[TB] late lv_data_v");
    cnt = '{3, 4, 5, 4, 3, 4, 5, 4, 3, 4, 5, 6};
    randomRgb();
    applyStimulus(100, 21, -1, "late_dv");

    $display("[TB] reset mid-stream");
    cnt = '{5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5};
    randomRgb();
    applyStimulus(100, 0, 17, "midrst");
    #1;
    checkOutput("post_rst_ready", notes_ready, 1);

    $display("[TB] fresh frame after reset");
    for (int b = 0; b < BIN_QTY; b++) cnt[b] = $urandom_range(1, 7);
    randomRgb();
    applyStimulus(70, 0, -1, "fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
